// File: rtl/ifu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifu_pkg
// Description : Shared types and constants for the instruction fetch unit.
// Revision    : 1.0
// ============================================================================
package ifu_pkg;

    typedef enum logic [2:0] {
        ST_BOOT = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_ERR  = 3'd4
    } ifu_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] INST_BYTES       = 32'd4;

    function automatic logic word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifu.sv
`default_nettype none
// ============================================================================
// Module      : ifu
// Description : Single-outstanding instruction fetch unit with redirect kill.
// Revision    : 1.0
// ============================================================================
module ifu #(
    parameter logic [31:0] RESET_PC = ifu_pkg::RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        mem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_err
);
    import ifu_pkg::*;

    ifu_state_t  r_state;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_pend_pc;
    logic        r_kill;
    logic [31:0] r_inst;
    logic [31:0] r_pc;
    logic        w_redirect_bad;

    assign w_redirect_bad = redirect_valid && !word_aligned(redirect_pc);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_BOOT;
            r_fetch_pc <= RESET_PC;
            r_pend_pc  <= RESET_PC;
            r_kill     <= 1'b0;
            r_inst     <= 32'd0;
            r_pc       <= RESET_PC;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    if (w_redirect_bad) begin
                        r_state <= ST_ERR;
                    end else begin
                        r_state <= ST_REQ;
                        if (redirect_valid) r_fetch_pc <= redirect_pc;
                    end
                end
                // The request address stays fixed until accepted; a redirect
                // here only arms the kill of the eventual response.
                ST_REQ: begin
                    if (w_redirect_bad) begin
                        r_state <= ST_ERR;
                    end else begin
                        if (redirect_valid) begin
                            r_pend_pc <= redirect_pc;
                            r_kill    <= 1'b1;
                        end
                        if (mem_req_ready) r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_redirect_bad) begin
                        r_state <= ST_ERR;
                    end else if (mem_rsp_valid) begin
                        if (r_kill || redirect_valid) begin
                            r_kill     <= 1'b0;
                            r_fetch_pc <= redirect_valid ? redirect_pc : r_pend_pc;
                            r_state    <= ST_REQ;
                        end else if (mem_rsp_err) begin
                            r_state <= ST_ERR;
                        end else begin
                            r_inst  <= mem_rsp_data;
                            r_pc    <= r_fetch_pc;
                            r_state <= ST_HOLD;
                        end
                    end else if (redirect_valid) begin
                        r_pend_pc <= redirect_pc;
                        r_kill    <= 1'b1;
                    end
                end
                // A redirect beats a same-cycle decode handshake.
                ST_HOLD: begin
                    if (w_redirect_bad) begin
                        r_state <= ST_ERR;
                    end else if (redirect_valid) begin
                        r_fetch_pc <= redirect_pc;
                        r_state    <= ST_REQ;
                    end else if (inst_ready) begin
                        r_fetch_pc <= r_pc + INST_BYTES;
                        r_state    <= ST_REQ;
                    end
                end
                ST_ERR: begin
                    r_state <= ST_ERR;
                end
                default: begin
                    r_state <= ST_ERR;
                end
            endcase
        end
    end

    assign mem_req_valid = (r_state == ST_REQ);
    assign mem_req_addr  = r_fetch_pc;
    assign inst_valid    = (r_state == ST_HOLD);
    assign inst          = r_inst;
    assign pc            = r_pc;
    assign fetch_err     = (r_state == ST_ERR);

endmodule
`default_nettype wire

// File: doc/ifu.md
# ifu

Instruction fetch unit for the single-issue multi-cycle NPC core. It owns the program counter and issues one word fetch at a time over a valid/ready instruction-memory port. It presents each fetched instruction and its PC to the decode stage through a valid/ready handshake. It accepts PC redirects from the execute stage for taken branches, JAL and JALR, and discards any fetch that the redirect made stale.

## Interface
Parameters:
- RESET_PC, 32'h8000_0000, PC of the first fetch after reset; must be 4-byte aligned.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- mem_req_valid  out  1  fetch request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_addr  out  32  fetch address, word aligned.
- mem_rsp_valid  in  1  fetch response valid, one cycle per response.
- mem_rsp_data  in  32  fetched instruction word.
- mem_rsp_err  in  1  access fault, qualified by mem_rsp_valid.
- inst_valid  out  1  instruction valid toward decode.
- inst_ready  in  1  decode consumes the instruction.
- inst  out  32  instruction word.
- pc  out  32  PC of `inst`.
- redirect_valid  in  1  next-PC override from execute; single-cycle pulse.
- redirect_pc  in  32  redirect target.
- fetch_err  out  1  sticky fault flag.

## Operation
States:
- **BOOT**
  - Entered on reset.
  - Moves to REQ on the next cycle.
- **REQ**
  - mem_req_valid=1 and mem_req_addr=fetch_pc.
  - On mem_req_valid & mem_req_ready, moves to WAIT.
- **WAIT**
  - Waits for mem_rsp_valid.
  - If the response is not stale, captures inst and pc, then moves to HOLD.
  - A non-stale response with mem_rsp_err=1 moves to ERR.
- **HOLD**
  - inst_valid=1.
  - On inst_valid & inst_ready: fetch_pc <= pc+4 (mod 2^32), then moves to REQ.
- **ERR**
  - fetch_err=1, mem_req_valid=0, inst_valid=0.
  - Left only by rst.

Redirect handling:
- **In BOOT or HOLD:**
  - fetch_pc <= redirect_pc, then move to REQ.
  - In HOLD the held instruction is dropped, even if inst_ready is high in the same cycle; redirect wins.
- **In REQ or WAIT:**
  - pend_pc <= redirect_pc and kill <= 1.
  - mem_req_addr stays stable until acceptance; a request is never withdrawn.
  - When the outstanding response arrives, it is discarded and its err is ignored.
  - kill clears, fetch_pc <= pend_pc, then move to REQ.
- **Repeated redirects:** a later redirect overwrites pend_pc.
- **Redirect in the same cycle as mem_rsp_valid in WAIT:** the response is discarded and the next REQ uses redirect_pc.
- **Misaligned target:** redirect_pc[1:0]!=0 moves to ERR instead.

Other rules:
- Only one request is ever outstanding.
- mem_rsp_valid outside WAIT is ignored.

## Timing
Reset values:
- mem_req_valid=0, mem_req_addr=RESET_PC.
- inst_valid=0, inst=0, pc=RESET_PC.
- fetch_err=0, kill=0.

Latency and throughput:
- First request appears on the first cycle after rst deasserts plus one (BOOT).
- Request accepted at cycle N, response at N+k (k>=1), inst_valid registered at N+k+1.
- Minimum steady-state rate is one instruction per 3 cycles: REQ, WAIT, HOLD with immediate ready.

Output rules:
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- inst and pc hold stable while inst_valid=1 and inst_ready=0.
- rst asserted mid-fetch aborts everything; a late response after reset arrives outside WAIT and is ignored.

## Structure
- Shared package `ifu_pkg` contains:
  - state enum (BOOT, REQ, WAIT, HOLD, ERR);
  - RESET_PC default;
  - INST_BYTES=4.
- No sub-module. Single module with:
  - one state register;
  - fetch_pc, pend_pc and kill registers;
  - output registers for inst and pc.

## Test plan
- **Reset and straight-line fetch:** memory with 1-cycle latency and inst_ready=1 -> fetches 8000_0000, 8000_0004, 8000_0008 at one instruction per 3 cycles; pc matches each word.
- **Decode backpressure:** hold inst_ready=0 for 5 cycles in HOLD -> inst and pc stable; no new mem_req_valid; fetch of pc+4 starts the cycle after ready.
- **Redirect during WAIT:** memory latency 4 with redirect to 8000_0100 -> stale word never reaches decode; next request address is 8000_0100.
- **Redirect in HOLD with inst_ready=1 same cycle:** held instruction dropped; next fetch from redirect_pc.
- **Back-to-back redirects while waiting:** targets 8000_0200 then 8000_0300 -> only 8000_0300 is fetched.
- **Faults:**
  - mem_rsp_err on a non-stale response -> fetch_err=1 and no further requests until rst.
  - redirect_pc=8000_0002 -> ERR.
  - mem_rsp_err on a stale response -> ignored.
